// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - RV32 execute stage: funct decode, yAlu, registered result behind valid/ready
// Optional 2-entry main+skid buffer with registered in_ready when ALU_EX_SKID_EN is defined.
module alu_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic             in_is_rtype,
  input  logic             in_is_branch,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_taken,
  output logic             out_wen,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        taken;
    logic        wen;
    logic [4:0]  rd;
    logic        illegal;
  } payload_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b011;

  function automatic logic [31:0] y_alu(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      OP_AND:  y_alu = a & b;
      OP_OR:   y_alu = a | b;
      OP_ADD:  y_alu = a + b;
      OP_SUB:  y_alu = a - b;
      default: y_alu = 32'h0;
    endcase
  endfunction

  logic [2:0]  alu_op;
  logic        dec_illegal;
  logic [31:0] alu_z;
  logic        alu_zero;
  payload_t    new_p;
  logic        in_fire;

  // Branch flag wins over the R-type flag; illegal codes force the no-op encoding.
  always_comb begin
    alu_op      = OP_NOP;
    dec_illegal = 1'b0;
    if (in_is_branch) begin
      alu_op      = OP_SUB;
      dec_illegal = (in_funct3[2:1] != 2'b00);
    end else begin
      case (in_funct3)
        3'b000:  alu_op = (in_is_rtype && in_funct7b5) ? OP_SUB : OP_ADD;
        3'b111:  alu_op = OP_AND;
        3'b110:  alu_op = OP_OR;
        default: dec_illegal = 1'b1;
      endcase
    end
    if (dec_illegal) alu_op = OP_NOP;
  end

  assign alu_z    = y_alu(alu_op, in_a, in_b);
  assign alu_zero = (alu_z == 32'h0);

  always_comb begin
    new_p         = '0;
    new_p.result  = alu_z;
    new_p.zero    = alu_zero;
    new_p.taken   = in_is_branch && !dec_illegal && (in_funct3[0] ? !alu_zero : alu_zero);
    new_p.wen     = !in_is_branch && !dec_illegal && (in_rd != 5'd0);
    new_p.rd      = in_rd;
    new_p.illegal = dec_illegal;
  end

  assign in_fire = in_valid && in_ready;

  logic     main_valid;
  payload_t main_q;

`ifdef ALU_EX_SKID_EN
  logic     skid_valid;
  payload_t skid_q;
  logic     in_ready_q;

  assign in_ready = in_ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_q     <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (!main_valid || out_ready) begin
        // Main drains this edge: skid has priority since it holds the older op.
        if (skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (in_fire) begin
          main_q     <= new_p;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_q     <= new_p;
        skid_valid <= 1'b1;
      end
      in_ready_q <= !(main_valid && !out_ready && (skid_valid || in_fire));
    end
  end
`else
  assign in_ready = !main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_q     <= '0;
    end else if (in_ready) begin
      main_valid <= in_valid;
      if (in_valid) main_q <= new_p;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (in_fire) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  assign out_valid   = main_valid;
  assign out_result  = main_q.result;
  assign out_zero    = main_q.zero;
  assign out_taken   = main_q.taken;
  assign out_wen     = main_q.wen;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - self-checking bench for alu_ex_stage
module tb_alu_ex_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        b5;
    logic        isr;
    logic        isb;
    logic [4:0]  rd;
  } op_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        taken;
    logic        wen;
    logic [4:0]  rd;
    logic        illegal;
  } res_t;

  typedef struct packed {
    op_t  op;
    res_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [2:0]  in_funct3;
  logic        in_funct7b5, in_is_rtype, in_is_branch;
  logic [4:0]  in_rd, out_rd;
  logic        out_zero, out_taken, out_wen, out_illegal;
  logic [15:0] op_count;
  logic        w_in_ready, w_out_valid, w_zero, w_taken, w_wen, w_illegal;
  logic [31:0] w_result;
  logic [4:0]  w_rd;
  logic [1:0]  op_count_w;

  always #5 clk = ~clk;

  alu_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_is_rtype(in_is_rtype), .in_is_branch(in_is_branch), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_taken(out_taken), .out_wen(out_wen), .out_rd(out_rd),
    .out_illegal(out_illegal), .op_count(op_count)
  );

  alu_ex_stage #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_is_rtype(in_is_rtype), .in_is_branch(in_is_branch), .in_rd(in_rd),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_result(w_result),
    .out_zero(w_zero), .out_taken(w_taken), .out_wen(w_wen), .out_rd(w_rd),
    .out_illegal(w_illegal), .op_count(op_count_w)
  );

  int          checks = 0;
  int          errors = 0;
  res_t        sb[$];
  logic [31:0] cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input res_t e);
    chk({tag, ".result"},  out_result,  e.result);
    chk({tag, ".zero"},    32'(out_zero),    32'(e.zero));
    chk({tag, ".taken"},   32'(out_taken),   32'(e.taken));
    chk({tag, ".wen"},     32'(out_wen),     32'(e.wen));
    chk({tag, ".rd"},      32'(out_rd),      32'(e.rd));
    chk({tag, ".illegal"}, 32'(out_illegal), 32'(e.illegal));
  endtask

  // Reference: mnemonic-level semantics with plain 32-bit arithmetic.
  function automatic res_t model(input op_t o);
    res_t        r;
    logic [31:0] sum, dif;
    bit          ok;
    sum = o.a + o.b;
    dif = o.a - o.b;
    ok  = 1;
    r   = '0;
    r.rd = o.rd;
    if (o.isb) begin
      ok       = (o.f3 == 3'd0) || (o.f3 == 3'd1);
      r.result = dif;
      r.taken  = ok && ((o.f3 == 3'd0) == (o.a == o.b));
    end else begin
      case (o.f3)
        3'd0:    r.result = (o.isr && o.b5) ? dif : sum;
        3'd7:    r.result = o.a & o.b;
        3'd6:    r.result = o.a | o.b;
        default: ok = 0;
      endcase
    end
    if (!ok) r.result = 32'h0;
    r.illegal = !ok;
    r.zero    = (r.result == 32'h0);
    r.wen     = !o.isb && ok && (o.rd != 5'd0);
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a   = $urandom;
    o.b   = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
    o.f3  = 3'($urandom_range(0, 7));
    o.b5  = 1'($urandom_range(0, 1));
    o.isr = 1'($urandom_range(0, 1));
    o.isb = ($urandom_range(0, 3) == 0);
    o.rd  = 5'($urandom_range(0, 31));
    return o;
  endfunction

  // Called just after a rising edge; returns after the next rising edge (+1).
  task automatic step(input logic v, input logic r, input op_t o, output bit acc, output bit del);
    bit exp_rdy;
    in_valid = v; out_ready = r;
    in_a = o.a; in_b = o.b; in_funct3 = o.f3; in_funct7b5 = o.b5;
    in_is_rtype = o.isr; in_is_branch = o.isb; in_rd = o.rd;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (out_valid && sb.size() != 0) cmp_out("sb", sb[0]);
`ifdef ALU_EX_SKID_EN
    exp_rdy = (sb.size() < 2);
`else
    exp_rdy = (sb.size() == 0) || r;
`endif
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && in_ready;
    del = out_valid && r;
    @(posedge clk); #1;
    if (del && sb.size() != 0) void'(sb.pop_front());
    if (acc) begin
      sb.push_back(model(o));
      cnt++;
    end
    chk("op_count", 32'(op_count), {16'h0, cnt[15:0]});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.op_count", 32'(op_count), 0);
    cmp_out("rst", '0);
    sb.delete();
    cnt = 0;
    rst_n = 1'b1;
  endtask

  vec_t vecs[12];
  bit   acc, del;
  int   n_acc, n_del, k;
  op_t  bp_ops[4];

  initial begin
    vecs[0]  = '{op: '{32'd5, 32'd7, 3'd0, 1'b1, 1'b1, 1'b0, 5'd3},
                 exp: '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0}};
    vecs[1]  = '{op: '{32'h1234, 32'h1234, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0},
                 exp: '{32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0}};
    vecs[2]  = '{op: '{32'h1234, 32'h1234, 3'd1, 1'b0, 1'b0, 1'b1, 5'd0},
                 exp: '{32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0}};
    vecs[3]  = '{op: '{32'h7FFFFFFF, 32'd1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0},
                 exp: '{32'h80000000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0}};
    vecs[4]  = '{op: '{32'h7FFFFFFF, 32'd1, 3'd2, 1'b0, 1'b0, 1'b0, 5'd4},
                 exp: '{32'h0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1}};
    vecs[5]  = '{op: '{32'hF0, 32'h0F, 3'd6, 1'b0, 1'b1, 1'b0, 5'd31},
                 exp: '{32'hFF, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0}};
    vecs[6]  = '{op: '{32'hFF00, 32'h0FF0, 3'd7, 1'b0, 1'b1, 1'b0, 5'd7},
                 exp: '{32'h0F00, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0}};
    vecs[7]  = '{op: '{32'd9, 32'd9, 3'd1, 1'b0, 1'b1, 1'b0, 5'd2},
                 exp: '{32'h0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1}};
    vecs[8]  = '{op: '{32'd1, 32'd2, 3'd4, 1'b0, 1'b0, 1'b1, 5'd0},
                 exp: '{32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1}};
    vecs[9]  = '{op: '{32'hFFFFFFFF, 32'd1, 3'd0, 1'b0, 1'b1, 1'b0, 5'd1},
                 exp: '{32'h0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0}};
    vecs[10] = '{op: '{32'd3, 32'd4, 3'd0, 1'b1, 1'b0, 1'b0, 5'd5},
                 exp: '{32'd7, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0}};
    vecs[11] = '{op: '{32'd1, 32'd2, 3'd1, 1'b1, 1'b1, 1'b1, 5'd6},
                 exp: '{32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0}};

    in_a = 0; in_b = 0; in_funct3 = 0; in_funct7b5 = 0;
    in_is_rtype = 0; in_is_branch = 0; in_rd = 0;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, vecs[i].op, acc, del);
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 1);
      cmp_out($sformatf("vec%0d", i), vecs[i].exp);
      if (i == 4) chk("wrap.op_count", 32'(op_count_w), 1);
    end
    step(1'b0, 1'b1, '0, acc, del);

    // Backpressure: four back-to-back ANDs against a 3-cycle stall.
    for (int i = 0; i < 4; i++) bp_ops[i] = '{32'hF0F0_0000 + 32'(i), 32'hFFFF_FFFF, 3'd7, 1'b0, 1'b0, 1'b0, 5'(i + 8)};
    k = 0; n_del = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, bp_ops[k], acc, del);
      if (acc) k++;
    end
`ifdef ALU_EX_SKID_EN
    chk("bp.accepted", 32'(k), 2);
`else
    chk("bp.accepted", 32'(k), 1);
`endif
    for (int c = 0; c < 20 && (k < 4 || sb.size() != 0); c++) begin
      step(k < 4, 1'b1, (k < 4) ? bp_ops[k] : '0, acc, del);
      if (acc) k++;
      if (del) n_del++;
    end
    chk("bp.all_accepted", 32'(k), 4);
    chk("bp.delivered", 32'(n_del), 4);

    // Reset while stalled drops held data.
    step(1'b1, 1'b0, rand_op(), acc, del);
    step(1'b1, 1'b0, rand_op(), acc, del);
    do_reset();
    step(1'b1, 1'b1, vecs[0].op, acc, del);
    cmp_out("post_rst", vecs[0].exp);

    for (int c = 0; c < 400; c++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7), rand_op(), acc, del);
    for (int c = 0; c < 10 && sb.size() != 0; c++) step(1'b0, 1'b1, '0, acc, del);
    chk("drain.empty", 32'(sb.size()), 0);
    chk("final.op_count_w", 32'(op_count_w), {30'h0, cnt[1:0]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute-stage pipeline block in front of `yAlu`. It decodes RV32 funct fields into the 3-bit `yAlu` op, drives `yAlu` with the latched operands, and registers the result, zero flag and branch decision behind a valid/ready handshake. It sits between the decode/register-read stage upstream and the writeback stage downstream.

## Interface
- `CNT_W`, default 16: width of the accepted-operation counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  active-low reset, synchronous to `clk` (sampled on the rising edge).
- `in_valid`  in  1  upstream holds a valid operation.
- `in_ready`  out  1  stage can accept this cycle.
- `in_a`  in  32  rs1 value.
- `in_b`  in  32  rs2 value or sign-extended immediate.
- `in_funct3`  in  3  instruction funct3.
- `in_funct7b5`  in  1  instruction bit 30.
- `in_is_rtype`  in  1  register-register ALU operation.
- `in_is_branch`  in  1  conditional branch; takes priority over `in_is_rtype`.
- `in_rd`  in  5  destination register.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_result`  out  32  `yAlu` z.
- `out_zero`  out  1  `yAlu` ex (z == 0).
- `out_taken`  out  1  branch taken.
- `out_wen`  out  1  write `out_rd`.
- `out_rd`  out  5  destination register.
- `out_illegal`  out  1  funct field combination not supported.
- `op_count`  out  `CNT_W`  number of accepted operations.

## Operation
- Transfers: an input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- `yAlu` op encoding:
  - 000 = AND, 001 = OR, 010 = ADD, 110 = SUB.
  - Any other code makes z = 0.
- Branch decode (`in_is_branch=1`): op is SUB.
  - funct3 000 (BEQ): `taken = zero`.
  - funct3 001 (BNE): `taken = !zero`.
  - Any other funct3: illegal.
- R-type decode (`in_is_rtype=1`):
  - funct3 000 with b5=0 → ADD; with b5=1 → SUB.
  - funct3 111 → AND.
  - funct3 110 → OR.
  - Any other funct3: illegal.
- I-type decode (neither flag set):
  - funct3 000 → ADD, with b5 ignored.
  - funct3 111 → AND.
  - funct3 110 → OR.
  - Any other funct3: illegal.
- Illegal operations: op is 011, so result = 0 and zero = 1. `taken=0`, `wen=0`, `out_illegal=1`. The operation still flows through the stage and is counted.
- `out_wen` = !branch && !illegal && rd != 0.
- `out_taken` is 0 for all non-branch operations.
- Arithmetic: 32-bit two's complement. Overflow wraps silently; no carry or overflow output.
- `op_count` increments by 1 on each input transfer and wraps from all-ones to 0.

## Timing
- Latency: an operation accepted at edge N is presented on `out_*` with `out_valid=1` after edge N.
- `out_*` stay stable while `out_valid && !out_ready`.
- Reset (`rst_n=0` at an edge) clears every output to 0, except `in_ready`, which resets to 1. Any buffered operation is discarded.
- `rst_n=0` mid-stall drops held data. The first input transfer is possible at the first edge with `rst_n=1`.
- Simultaneous input and output transfer in one cycle is legal. The new operation replaces the old one with no bubble.
- `in_*` are ignored while `in_ready=0`, and ignored whenever `in_valid=0`.

## Configuration
- `ALU_EX_SKID_EN` defined:
  - 2-entry buffer (main plus skid).
  - `in_ready` is a register equal to "skid empty", with no combinational path from `out_ready`.
  - An input accepted while main is full and stalled goes to skid. `in_ready` drops the next cycle.
  - On the next output transfer, skid moves to main and `in_ready` returns to 1.
  - Sustains 1 op/cycle.
- Not defined:
  - Single output register.
  - `in_ready = !out_valid || out_ready`, which is combinational.
  - Same ordering and throughput; no skid storage.

## Test plan
- Reset: hold `rst_n=0` for 2 edges with `in_valid=1` → all `out_*`=0, `op_count`=0, `in_ready`=1, no transfer.
- R-type SUB, a=5, b=7, funct3=000, b5=1, rd=3, `out_ready=1` → next cycle result=32'hFFFFFFFE, zero=0, wen=1, rd=3, `op_count`=1.
- BEQ a=b=32'h1234, then BNE with the same values → first: taken=1, zero=1, wen=0; second: taken=0.
- I-type ADDI, a=32'h7FFFFFFF, b=1, rd=0 → result=32'h80000000, wen=0. Then funct3=010 → illegal=1, result=0, `op_count`=2.
- Backpressure: issue 4 back-to-back ANDs with `out_ready=0` for 3 cycles → `out_*` held stable. With `ALU_EX_SKID_EN`, exactly 2 accepted before `in_ready`=0. Release → in-order delivery, no loss or duplicate.
- Counter wrap: `CNT_W=2`, 5 transfers → `op_count` reads 1.
